// File: rtl/position_logger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | position_logger                                                            |
// | Watches robot pose, emits START/MOVE/TURN/STUCK records into a FIFO and    |
// | keeps saturating step/turn counters plus a stuck indicator.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module position_logger #(
   parameter int DEPTH       = 8,
   parameter int STUCK_LIMIT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  robot_row,
   input  logic [5:0]  robot_column,
   input  logic [2:0]  robot_orientation,
   output logic        log_valid,
   output logic [16:0] log_data,
   input  logic        log_ready,
   output logic [15:0] step_count,
   output logic [15:0] turn_count,
   output logic        stuck,
   output logic        overflow
);

   localparam int           c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL   = (c_AW + 1)'(DEPTH);
   localparam logic [c_AW:0] c_ONE    = (c_AW + 1)'(1);
   localparam logic [15:0]  c_LIMIT   = 16'(STUCK_LIMIT);
   localparam logic [15:0]  c_CNT_MAX = 16'hFFFF;
   localparam logic [1:0]   c_T_MOVE  = 2'b00;
   localparam logic [1:0]   c_T_TURN  = 2'b01;
   localparam logic [1:0]   c_T_STUCK = 2'b10;
   localparam logic [1:0]   c_T_START = 2'b11;

   // Pose history and event state
   logic        r_first;
   logic [5:0]  r_prev_row;
   logic [5:0]  r_prev_col;
   logic [2:0]  r_prev_ori;
   logic [15:0] r_idle;
   logic        r_stuck;
   logic [15:0] r_step;
   logic [15:0] r_turn;
   logic        r_ovf;

   // FIFO storage and bookkeeping
   logic [16:0]     r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   logic        w_pos_chg;
   logic        w_ori_chg;
   logic        w_change;
   logic        w_idle_hit;
   logic        w_push;
   logic [1:0]  w_type;
   logic [16:0] w_rec;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_wr_en;
   logic        w_drop;

   assign w_pos_chg = (robot_row != r_prev_row) || (robot_column != r_prev_col);
   assign w_ori_chg = (robot_orientation != r_prev_ori);
   assign w_change  = !r_first && (w_pos_chg || w_ori_chg);

   // Idle counter saturates at the limit, so the hit fires only once per idle stretch
   assign w_idle_hit = !r_first && !w_change && (r_idle == (c_LIMIT - 16'd1));
   assign w_push     = r_first || w_change || w_idle_hit;

   always_comb begin
      w_type = c_T_STUCK;
      if (r_first) begin
         w_type = c_T_START;
      end else if (w_pos_chg) begin
         w_type = c_T_MOVE;
      end else if (w_ori_chg) begin
         w_type = c_T_TURN;
      end
   end

   assign w_rec = {w_type, robot_row, robot_column, robot_orientation};

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && log_ready;
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_first    <= 1'b1;
         r_prev_row <= '0;
         r_prev_col <= '0;
         r_prev_ori <= '0;
         r_idle     <= '0;
         r_stuck    <= 1'b0;
         r_step     <= '0;
         r_turn     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_first    <= 1'b0;
         r_prev_row <= robot_row;
         r_prev_col <= robot_column;
         r_prev_ori <= robot_orientation;

         if (w_change) begin
            r_idle  <= '0;
            r_stuck <= 1'b0;
            if (w_pos_chg && (r_step != c_CNT_MAX)) begin
               r_step <= r_step + 16'd1;
            end
            if (w_ori_chg && (r_turn != c_CNT_MAX)) begin
               r_turn <= r_turn + 16'd1;
            end
         end else if (!r_first && (r_idle != c_LIMIT)) begin
            r_idle <= r_idle + 16'd1;
         end

         if (w_idle_hit) begin
            r_stuck <= 1'b1;
         end

         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed while log_valid is high
   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_rec;
      end
   end

   assign log_valid  = !w_empty;
   assign log_data   = r_mem[r_rd_ptr];
   assign step_count = r_step;
   assign turn_count = r_turn;
   assign stuck      = r_stuck;
   assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_position_logger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_position_logger                                                         |
// | Directed and random stimulus against a queue-based event model.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_position_logger;

   localparam int c_DEPTH = 8;
   localparam int c_LIMIT = 4;

   logic        clock;
   logic        reset;
   logic [5:0]  robot_row;
   logic [5:0]  robot_column;
   logic [2:0]  robot_orientation;
   logic        log_valid;
   logic [16:0] log_data;
   logic        log_ready;
   logic [15:0] step_count;
   logic [15:0] turn_count;
   logic        stuck;
   logic        overflow;

   position_logger #(.DEPTH(c_DEPTH), .STUCK_LIMIT(c_LIMIT)) dut (
      .clock             (clock),
      .reset             (reset),
      .robot_row         (robot_row),
      .robot_column      (robot_column),
      .robot_orientation (robot_orientation),
      .log_valid         (log_valid),
      .log_data          (log_data),
      .log_ready         (log_ready),
      .step_count        (step_count),
      .turn_count        (turn_count),
      .stuck             (stuck),
      .overflow          (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   logic [16:0] m_q[$];
   bit          m_first;
   logic [5:0]  m_row;
   logic [5:0]  m_col;
   logic [2:0]  m_ori;
   int          m_idle;
   bit          m_stuck;
   int          m_step;
   int          m_turn;
   bit          m_ovf;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_first = 1'b1;
      m_idle  = 0;
      m_stuck = 1'b0;
      m_step  = 0;
      m_turn  = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(log_valid), 32'd0);
      check({tag, "_step"},  32'(step_count), 32'd0);
      check({tag, "_turn"},  32'(turn_count), 32'd0);
      check({tag, "_stuck"}, 32'(stuck), 32'd0);
      check({tag, "_ovf"},   32'(overflow), 32'd0);
   endtask

   task automatic check_outputs();
      check("valid", 32'(log_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("data", 32'(log_data), 32'(m_q[0]));
      check("step",  32'(step_count), 32'(m_step));
      check("turn",  32'(turn_count), 32'(m_turn));
      check("stuck", 32'(stuck), 32'(m_stuck));
      check("ovf",   32'(overflow), 32'(m_ovf));
   endtask

   // Predict the effect of the coming edge from the current inputs, then check after it.
   task automatic tick();
      bit          pop;
      bit          has_push;
      bit          pc;
      bit          oc;
      logic [16:0] rec;
      logic [14:0] pose;
      pose     = {robot_row, robot_column, robot_orientation};
      pop      = (m_q.size() != 0) && log_ready;
      has_push = 1'b0;
      rec      = '0;
      pc       = (robot_row != m_row) || (robot_column != m_col);
      oc       = (robot_orientation != m_ori);
      if (m_first) begin
         has_push = 1'b1;
         rec      = {2'b11, pose};
         m_first  = 1'b0;
      end else if (pc || oc) begin
         has_push = 1'b1;
         rec      = {(pc ? 2'b00 : 2'b01), pose};
         if (pc && m_step < 65535) m_step++;
         if (oc && m_turn < 65535) m_turn++;
         m_idle  = 0;
         m_stuck = 1'b0;
      end else if (m_idle < c_LIMIT) begin
         m_idle++;
         if (m_idle == c_LIMIT) begin
            m_stuck  = 1'b1;
            has_push = 1'b1;
            rec      = {2'b10, pose};
         end
      end
      m_row = robot_row;
      m_col = robot_column;
      m_ori = robot_orientation;
      if (pop) void'(m_q.pop_front());
      if (has_push) begin
         if (m_q.size() < c_DEPTH) m_q.push_back(rec);
         else m_ovf = 1'b1;
      end
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   // Called at posedge+1: assert reset asynchronously, hold over one edge, release off-edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state({tag, "_async"});
      @(posedge clock);
      #1;
      check_reset_state({tag, "_held"});
      model_reset();
      reset = 1'b1;
   endtask

   task automatic next_col();
      robot_column = (robot_column == 6'd4) ? 6'd5 : 6'd4;
   endtask

   initial begin
      reset             = 1'b0;
      robot_row         = 6'd2;
      robot_column      = 6'd3;
      robot_orientation = 3'd0;
      log_ready         = 1'b1;
      model_reset();
      m_row = '0;
      m_col = '0;
      m_ori = '0;
      @(posedge clock);
      #1;
      check_reset_state("por");
      reset = 1'b1;

      // START record then basic move and turn
      tick();
      check("start_rec", 32'(log_data), 32'({2'b11, 6'd2, 6'd3, 3'd0}));
      tick();
      robot_column = 6'd4;
      tick();
      check("move_rec", 32'(log_data), 32'({2'b00, 6'd2, 6'd4, 3'd0}));
      tick();
      robot_orientation = 3'd3;
      tick();
      check("turn_rec", 32'(log_data), 32'({2'b01, 6'd2, 6'd4, 3'd3}));
      check("step_1", 32'(step_count), 32'd1);
      check("turn_1", 32'(turn_count), 32'd1);
      tick();

      // Simultaneous move and turn: one MOVE record, both counters step
      robot_row         = 6'd5;
      robot_orientation = 3'd1;
      tick();
      check("combo_type", 32'(log_data[16:15]), 32'd0);
      tick();

      // Stuck detection with a hold after START
      do_reset("stk");
      log_ready = 1'b0;
      tick();
      for (int i = 0; i < c_LIMIT; i++) tick();
      check("stuck_hi", 32'(stuck), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      robot_row = 6'd6;
      tick();
      check("stuck_lo", 32'(stuck), 32'd0);
      log_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Overflow: START plus 10 moves into an 8-entry FIFO
      do_reset("ovf");
      log_ready = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         next_col();
         tick();
      end
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_step", 32'(step_count), 32'd10);
      log_ready = 1'b1;
      for (int i = 0; i < c_DEPTH + 2; i++) tick();

      // Full FIFO with simultaneous pop and push
      do_reset("full");
      log_ready = 1'b0;
      tick();
      for (int i = 0; i < c_DEPTH - 1; i++) begin
         next_col();
         tick();
      end
      log_ready = 1'b1;
      next_col();
      tick();
      check("full_noovf", 32'(overflow), 32'd0);
      log_ready = 1'b0;
      tick();
      log_ready = 1'b1;
      for (int i = 0; i < c_DEPTH + 1; i++) tick();

      // Reset while five records are queued
      do_reset("q5");
      log_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         next_col();
         tick();
      end
      do_reset("mid");
      tick();
      check("fresh_start", 32'(log_data[16:15]), 32'd3);
      log_ready = 1'b1;
      tick();

      // Random phase
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) robot_row = 6'($urandom_range(10, 1));
         if ($urandom_range(3) == 0) robot_column = 6'($urandom_range(20, 1));
         if ($urandom_range(4) == 0) robot_orientation = 3'($urandom_range(3));
         log_ready = ($urandom_range(2) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/position_logger.md
POSITION_LOGGER -- requirements
Module: position_logger

Interface
REQ-001 Parameter DEPTH, default 8, number of entries in the event FIFO (power of two, 2..64).
REQ-002 Parameter STUCK_LIMIT, default 64, consecutive no-change cycles before a stuck event (1..65535).
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; takes effect immediately on assertion, independent of clock.
REQ-005 robot_row  input  6  current robot row from the world model (1..10).
REQ-006 robot_column  input  6  current robot column from the world model (1..20).
REQ-007 robot_orientation  input  3  current heading (north=0, south=1, east=2, west=3).
REQ-008 log_valid  output  1  FIFO head holds a record.
REQ-009 log_data  output  17  head record {type[16:15], row[14:9], column[8:3], orientation[2:0]}.
REQ-010 log_ready  input  1  consumer accepts head record this cycle.
REQ-011 step_count  output  16  number of move events since reset.
REQ-012 turn_count  output  16  number of turn events since reset.
REQ-013 stuck  output  1  high while no position/heading change for at least STUCK_LIMIT cycles.
REQ-014 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-015 Block SHALL hold a registered copy (prev) of row, column, orientation and a first-sample flag.
REQ-016 First clock after reset release: SHALL load prev from inputs and push one START record (type 11) carrying the sampled position; no counter change.
REQ-017 Afterwards, each cycle: row or column differs from prev -> MOVE event (type 00); else orientation differs -> TURN event (type 01); prev SHALL be updated every cycle.
REQ-018 If position and orientation change in the same cycle, one MOVE record SHALL be pushed and both step_count and turn_count SHALL increment.
REQ-019 Record fields SHALL carry the new (current input) values, not prev.
REQ-020 step_count and turn_count SHALL saturate at 16'hFFFF, never wrap.
REQ-021 Idle counter SHALL increment on each no-change cycle (saturating at STUCK_LIMIT) and clear to 0 on any change.
REQ-022 On the cycle the idle counter reaches STUCK_LIMIT: stuck SHALL rise and one STUCK record (type 10, current position) SHALL be pushed; no further STUCK records until a change occurs.
REQ-023 stuck SHALL fall on the clock edge at which a change is detected; that change produces its normal MOVE/TURN record.
REQ-024 Push latency: record written at the edge where the event is detected; log_valid high the following cycle if FIFO was empty (one-cycle latency).
REQ-025 Pop: when log_valid and log_ready are both high at an edge, head SHALL advance; log_ready with log_valid low has no effect.
REQ-026 log_data SHALL be stable while log_valid is high and log_ready is low.
REQ-027 Full FIFO, push without pop: record SHALL be dropped, overflow set, FIFO contents unchanged.
REQ-028 Full FIFO, push with pop same cycle: both SHALL occur; no drop; occupancy stays DEPTH.
REQ-029 Empty FIFO, push and log_ready same cycle: no pop (log_valid low); record becomes head next cycle.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy tracked with a count of width log2(DEPTH)+1.

Reset
REQ-031 Reset low SHALL immediately force: log_valid=0, FIFO empty, step_count=0, turn_count=0, stuck=0, overflow=0, idle counter=0, first-sample flag set.
REQ-032 Reset asserted mid-operation SHALL discard all queued records; after release behaviour restarts at REQ-016.
REQ-033 log_data value during reset and while log_valid=0 is don't-care.

Verification
REQ-034 Release reset with inputs row=2,col=3,orient=0, log_ready=1 -> one record 11/2/3/0 on log_valid the second cycle; counts 0.
REQ-035 Change col 3->4 then orient 0->3 two cycles later -> records 00/2/4/0 then 01/2/4/3; step_count=1, turn_count=1.
REQ-036 Hold inputs constant STUCK_LIMIT=4 cycles after START -> stuck=1 and exactly one 10 record; next change clears stuck and emits MOVE.
REQ-037 log_ready=0, DEPTH=8, generate 10 move events after START -> 8 records held (START + 7 moves), overflow=1, step_count=10; draining yields records in order.
REQ-038 Full FIFO with log_ready=1 and a move event same cycle -> no drop, overflow stays 0, occupancy 8.
REQ-039 Assert reset while 5 records are queued -> log_valid drops immediately, all counts 0; after release only a fresh START record appears.
